// File: rtl/dff_result_checker.sv
// Compares a DFF stage's registered output (test) against a golden value (pat) for NUM_CHECKS samples.
// Optional macro CHECK_STOP_ON_ERROR_EN: halt the run on the first mismatch (adds the HALT state).
module dff_result_checker #(
    parameter int WIDTH      = 4,
    parameter int NUM_CHECKS = 10000
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] test,
    input  logic [WIDTH-1:0] pat,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [15:0]      sample_count,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx,
    output logic [WIDTH-1:0] first_err_test,
    output logic [WIDTH-1:0] first_err_pat,
    output logic [1:0]       state_dbg
);

    // Handshake: valid is a one-way qualifier with no back-pressure; a sample is
    // accepted on any rising edge where the block is in RUN and valid=1.
`ifdef CHECK_STOP_ON_ERROR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    localparam logic [15:0] LAST_IDX = 16'(NUM_CHECKS - 1);

    state_t state;
    logic   mismatch;
    logic   last_sample;

    assign mismatch    = (test != pat);
    assign last_sample = (sample_count == LAST_IDX);
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            sample_count   <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_test <= '0;
            first_err_pat  <= '0;
        end else if (state != RUN) begin
            // Outside RUN only start matters; a coincident valid is dropped.
            if (start) begin
                state          <= RUN;
                busy           <= 1'b1;
                done           <= 1'b0;
                pass           <= 1'b0;
                fail           <= 1'b0;
                sample_count   <= '0;
                err_count      <= '0;
                first_err_idx  <= '0;
                first_err_test <= '0;
                first_err_pat  <= '0;
            end
        end else if (valid) begin
            sample_count <= sample_count + 16'd1;
            if (mismatch) begin
                fail <= 1'b1;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (!fail) begin
                    first_err_idx  <= sample_count;
                    first_err_test <= test;
                    first_err_pat  <= pat;
                end
            end
`ifdef CHECK_STOP_ON_ERROR_EN
            if (mismatch) begin
                state <= HALT;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b0;
            end else
`endif
            if (last_sample) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= !mismatch && (err_count == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_dff_result_checker.sv
// Randomized scoreboard bench for dff_result_checker; reference model keeps the list of accepted samples.
module tb_dff_result_checker;
    localparam int W  = 4;
    localparam int N  = 16;
    localparam int NB = 65535;
    localparam int PW = 4 + 48 + 2 * W;

`ifdef CHECK_STOP_ON_ERROR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (NUM_CHECKS=16)
    logic         clr_n = 1'b0, start = 1'b0, valid = 1'b0;
    logic [W-1:0] test = '0, pat = '0;
    logic         busy, done, pass, fail;
    logic [15:0]  sample_count, err_count, first_err_idx;
    logic [W-1:0] first_err_test, first_err_pat;
    logic [1:0]   state_dbg;

    dff_result_checker #(.WIDTH(W), .NUM_CHECKS(N)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .valid(valid), .test(test), .pat(pat),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .sample_count(sample_count), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_test(first_err_test), .first_err_pat(first_err_pat), .state_dbg(state_dbg)
    );

    // Saturation instance (NUM_CHECKS=65535)
    logic         bclr_n = 1'b0, bstart = 1'b0, bvalid = 1'b0;
    logic [W-1:0] btest = '0, bpat = '0;
    logic         bbusy, bdone, bpass, bfail;
    logic [15:0]  bsample_count, berr_count, bfirst_err_idx;
    logic [W-1:0] bfirst_err_test, bfirst_err_pat;
    logic [1:0]   bstate_dbg;

    dff_result_checker #(.WIDTH(W), .NUM_CHECKS(NB)) dut_big (
        .clk(clk), .clr_n(bclr_n), .start(bstart), .valid(bvalid), .test(btest), .pat(bpat),
        .busy(bbusy), .done(bdone), .pass(bpass), .fail(bfail),
        .sample_count(bsample_count), .err_count(berr_count), .first_err_idx(bfirst_err_idx),
        .first_err_test(bfirst_err_test), .first_err_pat(bfirst_err_pat), .state_dbg(bstate_dbg)
    );

    logic [PW-1:0] dut_pk, big_pk;
    assign dut_pk = {busy, done, pass, fail, sample_count, err_count, first_err_idx,
                     first_err_test, first_err_pat};
    assign big_pk = {bbusy, bdone, bpass, bfail, bsample_count, berr_count, bfirst_err_idx,
                     bfirst_err_test, bfirst_err_pat};

    int n_cmp = 0;
    int n_err = 0;
    bit big_finished = 1'b0;

    // Scoreboard
    logic [PW-1:0]    exp_q[$];
    // Reference model: the run's accepted (test,pat) pairs plus run/ended flags
    logic [2*W-1:0]   acc_q[$];
    bit               m_run = 1'b0;
    bit               m_end = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_out();
        int           errs  = 0;
        int           first = -1;
        logic [W-1:0] ft    = '0;
        logic [W-1:0] fp    = '0;
        logic [15:0]  ec, fi;
        foreach (acc_q[i]) begin
            if (acc_q[i][2*W-1:W] != acc_q[i][W-1:0]) begin
                errs++;
                if (first < 0) begin
                    first = i;
                    ft    = acc_q[i][2*W-1:W];
                    fp    = acc_q[i][W-1:0];
                end
            end
        end
        ec = (errs > 65535) ? 16'hFFFF : 16'(errs);
        fi = (first < 0) ? 16'd0 : 16'(first);
        return {m_run, m_end, m_end && (errs == 0), errs > 0, 16'(acc_q.size()), ec, fi, ft, fp};
    endfunction

    function automatic void model_step(input bit s, input bit v, input logic [W-1:0] t,
                                       input logic [W-1:0] p);
        if (!m_run) begin
            if (s) begin
                m_run = 1'b1;
                m_end = 1'b0;
                acc_q.delete();
            end
        end else if (v) begin
            acc_q.push_back({t, p});
            if ((STOP_ON_ERR && t != p) || acc_q.size() == N) begin
                m_run = 1'b0;
                m_end = 1'b1;
            end
        end
    endfunction

    // Driver: present inputs, predict, wait for the consuming edge
    task automatic cycle(input bit s, input bit v, input logic [W-1:0] t, input logic [W-1:0] p);
        start = s;
        valid = v;
        test  = t;
        pat   = p;
        model_step(s, v, t, p);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        m_run = 1'b0;
        m_end = 1'b0;
        acc_q.delete();
        #1;
        check("reset_async", dut_pk, model_out());
        @(posedge clk);
        #2;
        clr_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] t = W'($urandom);
            cycle(1'b0, $urandom_range(0, 1) == 1, t, ~t);
        end
    endtask

    // Feed samples until target accepted (or run ends); bad0/bad1 are forced-mismatch indices
    task automatic feed(input int target, input int bad0, input int bad1, input bit gappy);
        for (int k = 0; k < 300 && m_run && acc_q.size() < target; k++) begin
            int           idx = acc_q.size();
            bit           v   = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
            logic [W-1:0] t   = W'($urandom);
            logic [W-1:0] p   = t;
            if (idx == bad0) begin
                t = 4'hA;
                p = 4'h5;
            end else if (idx == bad1) begin
                p = ~t;
            end
            cycle(1'b0, v, t, p);
        end
    endtask

    task automatic rand_run();
        cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 300 && m_run; k++) begin
            logic [W-1:0] t = W'($urandom);
            logic [W-1:0] p = ($urandom_range(0, 7) == 0) ? W'($urandom) : t;
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, t, p);
        end
        idle_cycles(3);
    endtask

    // Monitor: outputs are presented every cycle; compare just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check("outputs", dut_pk, exp_q.pop_front());
        end
    end

    // Saturation run on the large instance
    initial begin : big_run
        logic [W-1:0] f_t, f_p;
        logic [15:0]  exp_n;
        repeat (2) @(posedge clk);
        #2;
        bclr_n = 1'b1;
        bstart = 1'b1;
        @(posedge clk);
        #2;
        bstart = 1'b0;
        bvalid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            btest = W'($urandom);
            bpat  = ~btest;
            if (i == 0) begin
                f_t = btest;
                f_p = bpat;
            end
            @(posedge clk);
            #2;
        end
        bvalid = 1'b0;
        @(posedge clk);
        #2;
        exp_n = STOP_ON_ERR ? 16'd1 : 16'hFFFF;
        check("saturation", big_pk, {1'b0, 1'b1, 1'b0, 1'b1, exp_n, exp_n, 16'd0, f_t, f_p});
        big_finished = 1'b1;
    end

    initial begin : main
        @(posedge clk);
        #2;
        do_reset();
        idle_cycles(4);

        // All-matching run, gappy valid
        cycle(1'b1, 1'b0, '0, '0);
        feed(N, -1, -1, 1'b1);
        idle_cycles(3);

        // Restart from DONE; mismatches at index 5 (A vs 5) and 9
        cycle(1'b1, 1'b1, 4'h3, 4'h4);
        feed(N, 5, 9, 1'b0);
        idle_cycles(4);

        // Reset mid-run after 7 accepted samples, then a full run
        cycle(1'b1, 1'b0, '0, '0);
        feed(7, -1, -1, 1'b0);
        do_reset();
        idle_cycles(2);
        cycle(1'b1, 1'b0, '0, '0);
        feed(N, -1, -1, 1'b0);
        idle_cycles(2);

        // start+valid together in IDLE, valid held, start pulsed mid-run
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] t = W'($urandom);
            cycle(i == 0 || i == 8, 1'b1, t, t);
        end
        idle_cycles(2);

        for (int r = 0; r < 8; r++) rand_run();
        @(posedge clk);
        #2;

        for (int k = 0; k < 80000 && !big_finished; k++) @(posedge clk);
        n_cmp++;
        if (!big_finished) begin
            n_err++;
            $display("FAIL big_timeout: got not_finished expected finished");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dff_result_checker.md
DFF_RESULT_CHECKER -- requirements
Module: dff_result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: width of the compared data words.
REQ-002 The block SHALL have parameter NUM_CHECKS, default 10000: number of accepted samples per run, legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin a run.
REQ-006 The block SHALL have port valid, input, 1 bit: test and pat hold a sample this cycle.
REQ-007 The block SHALL have port test, input, WIDTH bits: registered output of the DFF stage under check.
REQ-008 The block SHALL have port pat, input, WIDTH bits: expected value from the golden model.
REQ-009 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: the run has ended, sticky.
REQ-011 The block SHALL have port pass, output, 1 bit: run ended with zero mismatches.
REQ-012 The block SHALL have port fail, output, 1 bit: at least one mismatch has been seen, sticky.
REQ-013 The block SHALL have port sample_count, output, 16 bits: samples accepted in this run.
REQ-014 The block SHALL have port err_count, output, 16 bits: mismatches in this run.
REQ-015 The block SHALL have port first_err_idx, output, 16 bits: sample index (0-based) of the first mismatch.
REQ-016 The block SHALL have port first_err_test, output, WIDTH bits: test value at the first mismatch.
REQ-017 The block SHALL have port first_err_pat, output, WIDTH bits: pat value at the first mismatch.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE and HALT (HALT exists only per REQ-034); state codes are internal.
REQ-019 IDLE->RUN on start=1; in the same edge, sample_count, err_count, first_err_* and fail are cleared to 0.
REQ-020 In IDLE, DONE and HALT, valid SHALL be ignored.
REQ-021 In RUN, each cycle with valid=1 SHALL be accepted: sample_count+1; if test!=pat, err_count+1.
REQ-022 On the first mismatch of a run, the block SHALL capture first_err_idx (the pre-increment sample_count), first_err_test and first_err_pat; later mismatches SHALL NOT overwrite them.
REQ-023 err_count SHALL saturate at 16'hFFFF.
REQ-024 All outputs SHALL be registered; every counter and flag SHALL update on the clk edge that accepts the sample (visible one cycle after valid is sampled).
REQ-025 The transition RUN->DONE SHALL occur on the edge that accepts sample number NUM_CHECKS; that sample SHALL be counted and compared.
REQ-026 busy=1 exactly in RUN; done=1 exactly in DONE or HALT; pass=done AND err_count==0; fail=1 from the first mismatch until the next start or reset.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 start in DONE or HALT SHALL re-enter RUN with the clearing of REQ-019.
REQ-029 start and valid together in IDLE/DONE/HALT: the sample SHALL NOT be accepted; acceptance begins the following cycle.

Reset
REQ-030 clr_n=0 SHALL asynchronously force state=IDLE and all outputs to 0, including first_err_*.
REQ-031 Reset asserted mid-run SHALL abandon the run without any sample being accepted on that edge.
REQ-032 After clr_n deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-033 The block SHALL support macro CHECK_STOP_ON_ERROR_EN.
REQ-034 With CHECK_STOP_ON_ERROR_EN defined, the first mismatch SHALL move RUN->HALT on the accepting edge (counters include that sample), and no further samples are accepted.
REQ-035 Without CHECK_STOP_ON_ERROR_EN, HALT SHALL NOT be implemented; mismatches SHALL be counted until NUM_CHECKS samples have been accepted.

Verification
REQ-036 Reset, start, then 16 matching samples with NUM_CHECKS=16 -> done=1, pass=1, fail=0, sample_count=16, err_count=0, busy=0.
REQ-037 NUM_CHECKS=16, mismatch at index 5 (test=4'hA, pat=4'h5) and at index 9 -> err_count=2, first_err_idx=5, first_err_test=4'hA, first_err_pat=4'h5, pass=0, fail=1 (macro undefined).
REQ-038 Same stimulus with CHECK_STOP_ON_ERROR_EN defined -> HALT after index 5, sample_count=6, err_count=1, done=1, later valid ignored.
REQ-039 clr_n pulsed low after 7 accepted samples -> all outputs 0 immediately, state IDLE; start then 16 samples -> sample_count=16.
REQ-040 start together with valid in IDLE, then valid held for 16 cycles -> first-cycle sample not counted, done asserted after the 16th cycle of RUN; start pulsed during RUN -> no effect.
REQ-041 NUM_CHECKS=65535, all samples mismatching -> err_count=16'hFFFF (no wrap), done=1.
